// File: rtl/egr_ppe_stm_mem_if.sv
// Table-memory interface between the egress PPE (master) and the stm responder (slave).
// Chunk c of any 576-bit word occupies bits [72c+71:72c] (64 data + 8 ECC).
interface egr_ppe_stm_mem_if;
    logic [7:0]        wen;
    logic [1:0][7:0]   ren;
    logic [2:0][17:0]  addr;
    logic [575:0]      wdata;
    logic [1:0][575:0] rdata;
    logic              init_done;
    logic              oor_err;

    modport master (output wen, ren, addr, wdata, input rdata, init_done, oor_err);
    modport slave  (input wen, ren, addr, wdata, output rdata, init_done, oor_err);
endinterface

// File: rtl/egr_ppe_stm_mem.sv
// Shared egress table memory: one chunk-masked write port, two fixed-latency read ports,
// write-first forwarding, post-reset zero sweep and out-of-range detection.
module egr_ppe_stm_mem #(
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    egr_ppe_stm_mem_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PD = (RD_LAT > 1) ? RD_LAT - 1 : 1;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                   state_q;
    logic [AW-1:0]            ptr_q;
    logic                     init_done_q;
    logic                     oor_q;
    logic [575:0]             mem_q [DEPTH];
    logic [PD-1:0][1:0][575:0] pipe_data_q;
    logic [PD-1:0][1:0][7:0]  pipe_en_q;
    logic [1:0][575:0]        rdata_q;

    logic                     wr_ok_s;
    logic [AW-1:0]            widx_s;
    logic [1:0][AW-1:0]       ridx_s;
    logic [1:0][575:0]        rd_val_s;
    logic [1:0][575:0]        rd_src_s;
    logic [1:0][7:0]          en_src_s;
    logic                     oor_s;

    // Upper address bits must all be zero; nothing aliases into the array.
    function automatic logic in_range(input logic [17:0] a);
        return (a >> AW) == 18'd0;
    endfunction

    // Write qualification, read data with write-first forwarding, and error detection.
    always_comb begin
        widx_s   = bus.addr[0][AW-1:0];
        wr_ok_s  = rst_n && (state_q == ST_READY) && in_range(bus.addr[0]);
        oor_s    = (state_q == ST_READY) && (bus.wen != 8'h00) && !in_range(bus.addr[0]);
        ridx_s   = '0;
        rd_val_s = '0;
        for (int p = 0; p < 2; p++) begin
            ridx_s[p] = bus.addr[p+1][AW-1:0];
            if (!in_range(bus.addr[p+1])) begin
                rd_val_s[p] = 576'd0;
                if (bus.ren[p] != 8'h00) begin
                    oor_s = 1'b1;
                end else begin
                    oor_s = oor_s;
                end
            end else if (state_q == ST_READY) begin
                rd_val_s[p] = mem_q[ridx_s[p]];
                for (int c = 0; c < 8; c++) begin
                    if (wr_ok_s && bus.wen[c] && (widx_s == ridx_s[p])) begin
                        rd_val_s[p][72*c +: 72] = bus.wdata[72*c +: 72];
                    end else begin
                        rd_val_s[p][72*c +: 72] = rd_val_s[p][72*c +: 72];
                    end
                end
            end else begin
                rd_val_s[p] = 576'd0;
            end
        end
    end

    // Final pipeline stage feeding rdata; with RD_LAT=1 the array read lands directly.
    always_comb begin
        if (RD_LAT == 1) begin
            rd_src_s = rd_val_s;
            en_src_s = bus.ren;
        end else begin
            rd_src_s = pipe_data_q[PD-1];
            en_src_s = pipe_en_q[PD-1];
        end
    end

    // Storage array: sweep zeroes one entry per cycle in INIT, chunk-masked writes in READY.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == ST_INIT)) begin
            mem_q[ptr_q] <= 576'd0;
        end else if (wr_ok_s) begin
            for (int c = 0; c < 8; c++) begin
                if (bus.wen[c]) begin
                    mem_q[widx_s][72*c +: 72] <= bus.wdata[72*c +: 72];
                end
            end
        end
    end

    // Sweep FSM, error pulse and read pipeline with per-chunk hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= '0;
            init_done_q <= 1'b0;
            oor_q       <= 1'b0;
            pipe_data_q <= '0;
            pipe_en_q   <= '0;
            rdata_q     <= '0;
        end else begin
            oor_q <= oor_s;
            case (state_q)
                ST_INIT: begin
                    init_done_q <= 1'b0;
                    ptr_q       <= ptr_q + AW'(1);
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                    end else begin
                        state_q <= ST_INIT;
                    end
                end
                ST_READY: begin
                    init_done_q <= 1'b1;
                    state_q     <= ST_READY;
                end
                default: begin
                    init_done_q <= 1'b0;
                    state_q     <= ST_INIT;
                end
            endcase
            pipe_data_q[0] <= rd_val_s;
            pipe_en_q[0]   <= bus.ren;
            for (int s = 1; s < PD; s++) begin
                pipe_data_q[s] <= pipe_data_q[s-1];
                pipe_en_q[s]   <= pipe_en_q[s-1];
            end
            for (int p = 0; p < 2; p++) begin
                for (int c = 0; c < 8; c++) begin
                    if (en_src_s[p][c]) begin
                        rdata_q[p][72*c +: 72] <= rd_src_s[p][72*c +: 72];
                    end
                end
            end
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.init_done = init_done_q;
    assign bus.oor_err   = oor_q;
endmodule

// File: tb/tb_egr_ppe_stm_mem.sv
// Bench for egr_ppe_stm_mem: directed scenarios plus randomized traffic against a
// queue-based reference model of the table memory.
module tb_egr_ppe_stm_mem;
    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 2;

    typedef struct {
        logic [1:0][575:0] d;
        logic [1:0][7:0]   m;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    egr_ppe_stm_mem_if bus();

    egr_ppe_stm_mem #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [575:0]      mem_m [DEPTH];
    req_t              pend[$];
    logic [1:0][575:0] exp_rdata;
    logic              exp_oor;
    int                edges_high;
    int                errors;
    int                checks;

    function automatic logic [71:0] chunk(input logic [7:0] b);
        return {9{b}};
    endfunction

    function automatic logic [575:0] pat(input logic [7:0] b);
        return {72{b}};
    endfunction

    task automatic set_idle();
        bus.wen   = 8'h00;
        bus.ren   = '0;
        bus.addr  = '0;
        bus.wdata = '0;
    endtask

    // One clock: model the request presented now, advance, then update expectations.
    task automatic step();
        req_t         r;
        req_t         done;
        logic         ready;
        logic         wr_ok;
        logic         oor;
        logic [7:0]   wen_s;
        logic [575:0] wd_s;
        int           waddr;
        ready = rst_n && (edges_high >= DEPTH);
        wen_s = bus.wen;
        wd_s  = bus.wdata;
        waddr = int'(bus.addr[0]);
        wr_ok = ready && (waddr < DEPTH) && (wen_s != 8'h00);
        oor   = ready && (wen_s != 8'h00) && (waddr >= DEPTH);
        for (int p = 0; p < 2; p++) begin
            int ra;
            ra = int'(bus.addr[p+1]);
            r.m[p] = bus.ren[p];
            if (ra >= DEPTH) begin
                r.d[p] = '0;
                if (bus.ren[p] != 8'h00) oor = 1'b1;
            end else if (!ready) begin
                r.d[p] = '0;
            end else begin
                r.d[p] = mem_m[ra];
                for (int c = 0; c < 8; c++)
                    if (wr_ok && wen_s[c] && (waddr == ra))
                        r.d[p][72*c +: 72] = wd_s[72*c +: 72];
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            edges_high = 0;
            pend.delete();
            exp_rdata = '0;
            exp_oor   = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else begin
            if (wr_ok)
                for (int c = 0; c < 8; c++)
                    if (wen_s[c]) mem_m[waddr][72*c +: 72] = wd_s[72*c +: 72];
            edges_high++;
            pend.push_back(r);
            if (pend.size() >= RD_LAT) begin
                done = pend.pop_front();
                for (int p = 0; p < 2; p++)
                    for (int c = 0; c < 8; c++)
                        if (done.m[p][c]) exp_rdata[p][72*c +: 72] = done.d[p][72*c +: 72];
            end
            exp_oor = oor;
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: got %h / %h, expected 0", bus.rdata[0], bus.rdata[1]);
        end
        checks++;
        if (bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_init_done: got %b, expected 0", bus.init_done);
        end
        checks++;
        if (bus.oor_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_oor_err: got %b, expected 0", bus.oor_err);
        end
    endtask

    task automatic test_init();
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            set_idle();
            if (edges_high == 3) begin bus.ren[0] = 8'hFF; bus.addr[1] = 18'd5; end
            if (edges_high == 4) begin bus.ren[1] = 8'h01; bus.addr[2] = 18'h01000; end
            if (edges_high == 6) begin bus.wen = 8'hFF; bus.addr[0] = 18'h3FFFF; bus.wdata = pat(8'hCC); end
            if (edges_high == 8) begin bus.wen = 8'hFF; bus.addr[0] = 18'd2; bus.wdata = pat(8'hCC); end
            step();
            if (edges_high == 3 + RD_LAT) begin
                checks++;
                if (bus.rdata[0] !== '0) begin
                    errors++;
                    $display("FAIL init_read: got %h, expected 0", bus.rdata[0]);
                end
            end
            if (edges_high == 5) begin
                checks++;
                if (bus.oor_err !== 1'b1) begin
                    errors++;
                    $display("FAIL init_oor_read: got %b, expected 1", bus.oor_err);
                end
            end
            if (edges_high == 7) begin
                checks++;
                if (bus.oor_err !== 1'b0) begin
                    errors++;
                    $display("FAIL init_oor_write: got %b, expected 0", bus.oor_err);
                end
            end
            if (edges_high == DEPTH) begin
                checks++;
                if (bus.init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL init_done_early: got %b, expected 0", bus.init_done);
                end
            end
            if (edges_high == DEPTH + 1) begin
                checks++;
                if (bus.init_done !== 1'b1) begin
                    errors++;
                    $display("FAIL init_done_rise: got %b, expected 1", bus.init_done);
                end
            end
        end
    endtask

    task automatic test_chunk_mask();
        logic [575:0] exp_a;
        exp_a = {{4{chunk(8'hAB)}}, {4{chunk(8'h55)}}};
        set_idle(); bus.wen = 8'hFF; bus.addr[0] = 18'h0000A; bus.wdata = pat(8'hAB); step();
        bus.wen = 8'h0F; bus.wdata = pat(8'h55); step();
        set_idle(); bus.ren[0] = 8'hFF; bus.addr[1] = 18'h0000A; step();
        set_idle();
        checks++;
        if (bus.rdata[0] !== '0) begin
            errors++;
            $display("FAIL mask_latency: got %h early, expected 0", bus.rdata[0]);
        end
        step();
        checks++;
        if (bus.rdata[0] !== exp_a) begin
            errors++;
            $display("FAIL mask_data: got %h, expected %h", bus.rdata[0], exp_a);
        end
    endtask

    task automatic test_read_hold();
        logic [575:0] exp_a;
        logic [575:0] exp_h;
        exp_a = {{4{chunk(8'hAB)}}, {4{chunk(8'h55)}}};
        exp_h = {exp_a[575:72], chunk(8'h11)};
        set_idle(); bus.wen = 8'hFF; bus.addr[0] = 18'h0000B; bus.wdata = pat(8'h11); step();
        set_idle(); bus.ren[1] = 8'hFF; bus.addr[2] = 18'h0000A; step();
        set_idle(); bus.ren[1] = 8'h01; bus.addr[2] = 18'h0000B; step();
        checks++;
        if (bus.rdata[1] !== exp_a) begin
            errors++;
            $display("FAIL hold_first: got %h, expected %h", bus.rdata[1], exp_a);
        end
        set_idle(); step();
        checks++;
        if (bus.rdata[1] !== exp_h) begin
            errors++;
            $display("FAIL hold_partial: got %h, expected %h", bus.rdata[1], exp_h);
        end
        checks++;
        if (bus.rdata[0] !== exp_a) begin
            errors++;
            $display("FAIL hold_idle_port: got %h, expected %h", bus.rdata[0], exp_a);
        end
    endtask

    task automatic test_collision();
        logic [575:0] exp_c;
        exp_c = {{4{chunk(8'h77)}}, {4{72'd0}}};
        set_idle();
        bus.wen = 8'hF0; bus.addr[0] = 18'h00020; bus.wdata = pat(8'h77);
        bus.ren = {8'hFF, 8'hFF}; bus.addr[1] = 18'h00020; bus.addr[2] = 18'h00020;
        step();
        set_idle(); step();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (bus.rdata[p] !== exp_c) begin
                errors++;
                $display("FAIL collision_p%0d: got %h, expected %h", p, bus.rdata[p], exp_c);
            end
        end
        set_idle();
        bus.wen = 8'h0F; bus.addr[0] = 18'h00021; bus.wdata = pat(8'h99);
        bus.ren[0] = 8'hFF; bus.addr[1] = 18'h00020;
        step();
        set_idle(); step();
        checks++;
        if (bus.rdata[0] !== exp_c) begin
            errors++;
            $display("FAIL collision_stored: got %h, expected %h", bus.rdata[0], exp_c);
        end
    endtask

    task automatic test_oor();
        set_idle();
        bus.ren[0] = 8'hFF; bus.addr[1] = 18'h01000;
        bus.wen = 8'h01; bus.addr[0] = 18'h3FFFF; bus.wdata = pat(8'hEE);
        step();
        checks++;
        if (bus.oor_err !== 1'b1) begin
            errors++;
            $display("FAIL oor_pulse: got %b, expected 1", bus.oor_err);
        end
        set_idle(); bus.addr = {3{18'h3FFFF}}; step();
        checks++;
        if (bus.oor_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_single: got %b, expected 0", bus.oor_err);
        end
        checks++;
        if (bus.rdata[0] !== '0) begin
            errors++;
            $display("FAIL oor_rdata: got %h, expected 0", bus.rdata[0]);
        end
        set_idle(); step();
        checks++;
        if (bus.oor_err !== 1'b0) begin
            errors++;
            $display("FAIL oor_no_enable: got %b, expected 0", bus.oor_err);
        end
        for (int i = 0; i < DEPTH / 2 + RD_LAT; i++) begin
            set_idle();
            if (i < DEPTH / 2) begin
                bus.ren = {8'hFF, 8'hFF};
                bus.addr[1] = 18'(i);
                bus.addr[2] = 18'(i + DEPTH / 2);
            end
            step();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (bus.rdata[p] !== exp_rdata[p]) begin
                    errors++;
                    $display("FAIL readback_p%0d step %0d: got %h, expected %h", p, i, bus.rdata[p], exp_rdata[p]);
                end
            end
        end
    endtask

    task automatic pick_addr(output logic [17:0] a);
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel == 0)      a = 18'h3FFFF;
        else if (sel == 1) a = 18'(DEPTH + int'($urandom_range(0, 3)));
        else               a = 18'($urandom_range(0, 15));
    endtask

    task automatic test_random();
        logic [17:0] a;
        for (int k = 0; k < 600; k++) begin
            set_idle();
            bus.wen = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            for (int w = 0; w < 18; w++) bus.wdata[32*w +: 32] = $urandom();
            for (int j = 0; j < 3; j++) begin
                pick_addr(a);
                bus.addr[j] = a;
            end
            bus.ren[0] = 8'($urandom());
            bus.ren[1] = 8'($urandom());
            step();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (bus.rdata[p] !== exp_rdata[p]) begin
                    errors++;
                    $display("FAIL random_rdata_p%0d cyc %0d: got %h, expected %h", p, k, bus.rdata[p], exp_rdata[p]);
                end
            end
            checks++;
            if (bus.oor_err !== exp_oor) begin
                errors++;
                $display("FAIL random_oor cyc %0d: got %b, expected %b", k, bus.oor_err, exp_oor);
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 6; k++) begin
            set_idle();
            bus.ren = {8'hFF, 8'hFF}; bus.addr[1] = 18'h0000A; bus.addr[2] = 18'h00020;
            step();
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.rdata !== '0) begin
            errors++;
            $display("FAIL midreset_rdata: got %h / %h, expected 0", bus.rdata[0], bus.rdata[1]);
        end
        checks++;
        if (bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_init_done: got %b, expected 0", bus.init_done);
        end
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH + 1; k++) begin
            set_idle();
            if (k < 8) begin
                bus.ren = {8'hFF, 8'hFF}; bus.addr[1] = 18'h0000A; bus.addr[2] = 18'h00020;
            end
            step();
            if (k < 12) begin
                checks++;
                if (bus.rdata !== '0) begin
                    errors++;
                    $display("FAIL midreset_stale k=%0d: got %h / %h, expected 0", k, bus.rdata[0], bus.rdata[1]);
                end
            end
            if (edges_high == DEPTH) begin
                checks++;
                if (bus.init_done !== 1'b0) begin
                    errors++;
                    $display("FAIL resweep_early: got %b, expected 0", bus.init_done);
                end
            end
            if (edges_high == DEPTH + 1) begin
                checks++;
                if (bus.init_done !== 1'b1) begin
                    errors++;
                    $display("FAIL resweep_done: got %b, expected 1", bus.init_done);
                end
            end
        end
        set_idle(); bus.wen = 8'hFF; bus.addr[0] = 18'h00001; bus.wdata = pat(8'h5A); step();
        set_idle(); bus.ren[0] = 8'hFF; bus.addr[1] = 18'h00001; step();
        set_idle(); bus.ren[0] = 8'hFF; bus.addr[1] = 18'h0000A; step();
        checks++;
        if (bus.rdata[0] !== pat(8'h5A)) begin
            errors++;
            $display("FAIL resweep_write: got %h, expected %h", bus.rdata[0], pat(8'h5A));
        end
        set_idle(); step();
        checks++;
        if (bus.rdata[0] !== '0) begin
            errors++;
            $display("FAIL resweep_cleared: got %h, expected 0", bus.rdata[0]);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        edges_high = 0;
        exp_rdata  = '0;
        exp_oor    = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        set_idle();
        test_reset();
        test_init();
        test_chunk_mask();
        test_read_hold();
        test_collision();
        test_oor();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/egr_ppe_stm_mem.md
Name: egr_ppe_stm_mem

Overview:
Shared table memory responder serving the egress PPE over the egr/stm table-memory interface. It has one write port and two read ports. Data is 576 bits: 8 chunks of 72 bits, each chunk 64 data + 8 ECC, stored as-is with no ECC check or generation here. The block owns the storage array, a post-reset zero-initialisation sweep, and the fixed-latency read pipeline with same-cycle write forwarding. It sits at the stm end of the interface, opposite the egress PPE initiator.

Parameters:
DEPTH, 4096, number of 576-bit entries; power of 2, range 16 to 262144.
RD_LAT, 2, read latency in cycles from request to rdata; range 1 to 4.
AW, $clog2(DEPTH), derived index width; not overridable.

Ports:
clk  input  1  block clock
rst_n  input  1  synchronous active-low reset
wen  input  8  per-chunk write enables; port 0
ren  input  2x8  per read port, per-chunk read enables; ren[p][c]
addr  input  3x18  addr[0] is the write address; addr[1], addr[2] are the read-port 0/1 addresses
wdata  input  576  write data incl. ECC; chunk c = bits [72c+71:72c]
rdata  output  2x576  read data per read port; rdata[p] is paired with addr[p+1]
init_done  output  1  high once the zero sweep completes
oor_err  output  1  one-cycle pulse on any enabled access with address >= DEPTH

Behaviour:
- Reset: synchronous, sampled on the rising edge of clk while rst_n=0. Reset values: rdata=0, init_done=0, oor_err=0, all read pipeline stages cleared, FSM in INIT with sweep pointer 0. Array contents are not reset directly; the sweep clears them.
- FSM: INIT to READY.
  - INIT: each cycle writes all 8 chunks of entry ptr to 0, then ptr++. Takes exactly DEPTH cycles. When ptr=DEPTH-1 is written, the next state is READY and init_done=1 on the following cycle.
  - INIT access rules: external wen is ignored. Read requests are accepted, and each enabled chunk returns 0 at RD_LAT.
  - READY: terminal state until reset.
- Reset mid-operation (INIT or READY): abandons in-flight reads (pipeline cleared, rdata=0) and restarts the sweep from ptr 0.
- Write (READY): on cycle T, for each chunk c with wen[c]=1, entry addr[0][AW-1:0] chunk c takes wdata chunk c. Chunks with wen[c]=0 are unchanged.
- Read, request in cycle T:
  - rdata[p] chunk c updates at the edge ending cycle T+RD_LAT-1, visible in cycle T+RD_LAT, only if ren[p][c]=1.
  - Chunks with ren[p][c]=0 hold their previous rdata value.
  - Ports are fully independent. Both ports on the same address are legal and return identical data.
  - Fully pipelined: a new request on every port every cycle, no stalls, no backpressure.
- Read/write collision, same cycle, same index:
  - A read chunk whose wen[c]=1 returns the new wdata chunk (write-first).
  - Other chunks return the stored value.
- Write at cycle T, read of the same entry at cycle T+1 or later: returns the written data. No hazard window.
- Address range: only addr[k][17:AW] = 0 is in range.
  - Out-of-range write with any wen set: dropped.
  - Out-of-range read chunk with ren set: returns 0.
  - Either case pulses oor_err in cycle T+1; multiple simultaneous errors give one pulse.
  - An out-of-range address with no enable set raises no error.
  - During INIT, oor_err is still reported for reads; writes are ignored and never flag.
- Aliasing: none. Upper address bits are compared, never truncated.
- Storage: behavioural flop/RAM array DEPTH x 576 with 8-bit chunk write mask. The memory-macro substitution point is the array read/write only; pipeline and forwarding logic remain in this block.

Test Plan:
- Init sweep: deassert rst_n, DEPTH=16 -> init_done rises exactly 17 cycles after the first rst_n=1 edge; a read of entry 5 at cycle 3 with ren[0]=8'hFF returns 0 at cycle 3+RD_LAT.
- Chunk masking: write addr 0x00A, wdata all-0xAB, wen=8'hFF; then write 0x00A, wdata all-0x55, wen=8'h0F -> read returns chunks 0-3 = 0x55 pattern, chunks 4-7 = 0xAB pattern, after exactly RD_LAT cycles.
- Read hold: port 1 reads 0x00A with ren[1]=8'hFF, next cycle reads 0x00B (all-0x11) with ren[1]=8'h01 -> rdata[1] chunk 0 = 0x11 pattern, chunks 1-7 retain the 0x00A data.
- Collision: same cycle, write 0x020 wen=8'hF0 wdata all-0x77 and port 0 reads 0x020 (previously 0) ren=8'hFF -> chunks 4-7 = 0x77, chunks 0-3 = 0.
- Out of range (DEPTH=4096): read addr 0x01000 ren=8'hFF plus write 0x3FFFF wen=8'h01 in the same cycle -> single oor_err pulse at T+1, rdata=0, and all 4096 entries unchanged on read-back.
- Reset mid-stream: issue back-to-back reads each cycle, assert rst_n=0 for 1 cycle -> rdata=0 next cycle, no stale data emerges, init_done=0 and the sweep reruns for DEPTH cycles.
